// File: rtl/powerup_scheduler.sv
// Power-up arbiter: turns per-band loudness from microphone histograms into one-at-a-time,
// frame-timed power-up grants for the graphics controller.
module powerup_scheduler #(
   parameter int SAMPLES         = 16,
   parameter int BIN_W           = 18,
   parameter int THRESH          = 4096,
   parameter int DEBOUNCE        = 3,
   parameter int HOLD_FRAMES     = 120,
   parameter int COOLDOWN_FRAMES = 300
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     enable,
   input  logic                     hist_done,
   input  logic [SAMPLES*BIN_W-1:0] magnitudes,
   input  logic                     vsync,
   output logic [4:0]               pu_out,
   output logic [2:0]               active_id,
   output logic                     busy,
   output logic                     overrun
);

   localparam int BW      = (SAMPLES - 1) / 5;
   localparam int NBINS   = 5 * BW;
   localparam int IDX_W   = $clog2(SAMPLES);
   localparam int ACC_W   = BIN_W + $clog2(SAMPLES);
   localparam int CNT_MAX = (HOLD_FRAMES > COOLDOWN_FRAMES) ? HOLD_FRAMES : COOLDOWN_FRAMES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {E_IDLE, E_SUM, E_UPD} e_state_t;
   typedef enum logic [1:0] {G_IDLE, G_ACTIVE, G_COOLDOWN} g_state_t;

   logic [BIN_W-1:0] mag_bin [SAMPLES];
   logic [BIN_W-1:0] bins_q  [SAMPLES];
   logic [BIN_W-1:0] bins_d  [SAMPLES];
   logic [3:0]       dbc_q   [5];
   logic [3:0]       dbc_d   [5];

   e_state_t         e_state_q, e_state_d;
   g_state_t         g_state_q, g_state_d;
   logic [IDX_W-1:0] bin_idx_q, bin_idx_d, pos_q, pos_d;
   logic [2:0]       band_q, band_d, rr_q, rr_d, id_q, id_d;
   logic [ACC_W-1:0] acc_q, acc_d, sum;
   logic [4:0]       loud_q, loud_d, pu_q, pu_d, pending;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d, overrun_q, overrun_d;
   logic             vsync_q, vsync_d, tick_q, tick_d;
   logic             found;
   logic [2:0]       sel;
   logic [3:0]       cand;

   generate
      for (genvar gi = 0; gi < SAMPLES; gi++) begin : g_unpack
         assign mag_bin[gi] = magnitudes[gi*BIN_W +: BIN_W];
      end
   endgenerate

   assign pu_out    = pu_q;
   assign active_id = id_q;
   assign busy      = busy_q;
   assign overrun   = overrun_q;

   always_comb begin
      e_state_d = e_state_q;
      g_state_d = g_state_q;
      bins_d    = bins_q;
      bin_idx_d = bin_idx_q;
      pos_d     = pos_q;
      band_d    = band_q;
      acc_d     = acc_q;
      loud_d    = loud_q;
      dbc_d     = dbc_q;
      overrun_d = overrun_q;
      rr_d      = rr_q;
      cnt_d     = cnt_q;
      pu_d      = pu_q;
      id_d      = id_q;
      busy_d    = busy_q;
      vsync_d   = vsync;
      tick_d    = vsync_q & ~vsync;
      sum       = acc_q + ACC_W'(bins_q[bin_idx_q]);
      found     = 1'b0;
      sel       = 3'd0;
      cand      = 4'd0;

      case (e_state_q)
         E_IDLE: if (hist_done) begin
            bins_d    = mag_bin;
            bin_idx_d = IDX_W'(1);
            pos_d     = '0;
            band_d    = 3'd0;
            acc_d     = '0;
            e_state_d = E_SUM;
         end
         E_SUM: begin
            // Band boundaries tracked by a position counter instead of dividing the bin index.
            if (pos_q == IDX_W'(BW - 1)) begin
               loud_d[band_q] = (sum >= ACC_W'(THRESH));
               acc_d          = '0;
               pos_d          = '0;
               band_d         = band_q + 3'd1;
            end else begin
               acc_d = sum;
               pos_d = pos_q + 1'b1;
            end
            bin_idx_d = bin_idx_q + 1'b1;
            if (bin_idx_q == IDX_W'(NBINS)) e_state_d = E_UPD;
         end
         E_UPD: begin
            for (int k = 0; k < 5; k++)
               dbc_d[k] = !loud_q[k] ? 4'd0 :
                          (dbc_q[k] == 4'(DEBOUNCE)) ? 4'(DEBOUNCE) : dbc_q[k] + 4'd1;
            e_state_d = E_IDLE;
         end
         default: e_state_d = E_IDLE;
      endcase

      if (hist_done && e_state_q != E_IDLE) overrun_d = 1'b1;
      if (!enable)
         for (int k = 0; k < 5; k++) dbc_d[k] = 4'd0;

      for (int k = 0; k < 5; k++) pending[k] = (dbc_q[k] == 4'(DEBOUNCE));
      for (int j = 0; j < 5; j++) begin
         cand = {1'b0, rr_q} + 4'(j);
         if (cand >= 4'd5) cand = cand - 4'd5;
         if (!found && pending[cand[2:0]]) begin
            found = 1'b1;
            sel   = cand[2:0];
         end
      end

      case (g_state_q)
         G_IDLE: if (enable && found) begin
            pu_d       = 5'd1 << sel;
            id_d       = sel;
            busy_d     = 1'b1;
            dbc_d[sel] = 4'd0;
            rr_d       = (sel == 3'd4) ? 3'd0 : sel + 3'd1;
            cnt_d      = '0;
            g_state_d  = G_ACTIVE;
         end
         G_ACTIVE: if (tick_q) begin
            if (cnt_q == CNT_W'(HOLD_FRAMES - 1)) begin
               pu_d  = 5'd0;
               id_d  = 3'd7;
               cnt_d = '0;
               if (COOLDOWN_FRAMES == 0) begin
                  busy_d    = 1'b0;
                  g_state_d = G_IDLE;
               end else begin
                  g_state_d = G_COOLDOWN;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         G_COOLDOWN: if (tick_q) begin
            if (cnt_q == CNT_W'(COOLDOWN_FRAMES - 1)) begin
               busy_d    = 1'b0;
               cnt_d     = '0;
               g_state_d = G_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: g_state_d = G_IDLE;
      endcase

      if (!enable) begin
         g_state_d = G_IDLE;
         pu_d      = 5'd0;
         id_d      = 3'd7;
         busy_d    = 1'b0;
         cnt_d     = '0;
      end
   end

   always_ff @(posedge clk) begin
      bins_q <= bins_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         e_state_q <= E_IDLE;
         g_state_q <= G_IDLE;
         bin_idx_q <= '0;
         pos_q     <= '0;
         band_q    <= 3'd0;
         acc_q     <= '0;
         loud_q    <= 5'd0;
         for (int k = 0; k < 5; k++) dbc_q[k] <= 4'd0;
         overrun_q <= 1'b0;
         rr_q      <= 3'd0;
         cnt_q     <= '0;
         pu_q      <= 5'd0;
         id_q      <= 3'd7;
         busy_q    <= 1'b0;
         vsync_q   <= 1'b1;
         tick_q    <= 1'b0;
      end else begin
         e_state_q <= e_state_d;
         g_state_q <= g_state_d;
         bin_idx_q <= bin_idx_d;
         pos_q     <= pos_d;
         band_q    <= band_d;
         acc_q     <= acc_d;
         loud_q    <= loud_d;
         dbc_q     <= dbc_d;
         overrun_q <= overrun_d;
         rr_q      <= rr_d;
         cnt_q     <= cnt_d;
         pu_q      <= pu_d;
         id_q      <= id_d;
         busy_q    <= busy_d;
         vsync_q   <= vsync_d;
         tick_q    <= tick_d;
      end
   end

endmodule

// File: tb/tb_powerup_scheduler.sv
// Directed bench for powerup_scheduler: expected grants are queued when the triggering
// histogram is issued and checked when the grant appears.
module tb_powerup_scheduler;
   localparam int SAMPLES = 16;
   localparam int BIN_W   = 18;

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic                     enable = 1'b0;
   logic                     hist_done = 1'b0;
   logic                     vsync = 1'b1;
   logic [SAMPLES*BIN_W-1:0] magnitudes = '0;
   logic [4:0]               pu_out, nc_pu_out;
   logic [2:0]               active_id, nc_active_id;
   logic                     busy, overrun, nc_busy, nc_overrun;

   int vectors = 0;
   int errors  = 0;
   int lat;

   typedef struct packed {
      logic [4:0] pu;
      logic [2:0] id;
   } grant_t;
   grant_t exp_q[$];

   always #5 clk = ~clk;

   powerup_scheduler dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .hist_done(hist_done),
      .magnitudes(magnitudes), .vsync(vsync), .pu_out(pu_out),
      .active_id(active_id), .busy(busy), .overrun(overrun)
   );

   // Short-hold, no-cooldown variant sharing the same stimulus.
   powerup_scheduler #(.HOLD_FRAMES(4), .COOLDOWN_FRAMES(0)) dut_nc (
      .clk(clk), .rst_n(rst_n), .enable(enable), .hist_done(hist_done),
      .magnitudes(magnitudes), .vsync(vsync), .pu_out(nc_pu_out),
      .active_id(nc_active_id), .busy(nc_busy), .overrun(nc_overrun)
   );

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_mags(input logic [4:0] mask, input int total);
      magnitudes = '0;
      for (int k = 0; k < 5; k++) begin
         if (mask[k]) begin
            magnitudes[(1+3*k)*BIN_W +: BIN_W] = BIN_W'(total - 2*(total/3));
            magnitudes[(2+3*k)*BIN_W +: BIN_W] = BIN_W'(total/3);
            magnitudes[(3+3*k)*BIN_W +: BIN_W] = BIN_W'(total/3);
         end
      end
   endtask

   task automatic hist_pulse();
      hist_done = 1'b1;
      step(1);
      hist_done = 1'b0;
   endtask

   task automatic apply_hist(input logic [4:0] mask, input int total);
      set_mags(mask, total);
      hist_pulse();
      step(63);
   endtask

   task automatic frames(input int n);
      repeat (n) begin
         vsync = 1'b0;
         step(2);
         vsync = 1'b1;
         step(2);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      set_mags(5'b11111, 6000);
      for (int i = 0; i < 5; i++) begin
         hist_done = ~hist_done;
         vsync     = ~vsync;
         step(1);
      end
      hist_done = 1'b0;
      vsync     = 1'b1;
      chk("rst_pu_out", pu_out, 5'd0);
      chk("rst_active_id", active_id, 3'd7);
      chk("rst_busy", busy, 1'b0);
      chk("rst_overrun", overrun, 1'b0);
      rst_n  = 1'b1;
      enable = 1'b1;
      set_mags(5'b00000, 0);
      step(2);
   endtask

   task automatic wait_grant(input int max, output int cycles);
      grant_t e;
      cycles = 0;
      while (pu_out == 5'd0 && cycles < max) begin
         step(1);
         cycles++;
      end
      chk("grant_seen", pu_out != 5'd0, 1'b1);
      chk("sb_nonempty", exp_q.size() != 0, 1'b1);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      chk("grant_pu_out", pu_out, e.pu);
      chk("grant_active_id", active_id, e.id);
      chk("grant_busy", busy, 1'b1);
   endtask

   initial begin
      // Reset with activity on inputs
      do_reset();

      // Band 1 debounced to a grant, held 120 frames, then 300 frames cooldown
      apply_hist(5'b00010, 6000);
      apply_hist(5'b00010, 6000);
      chk("t2_no_grant_before_3rd", pu_out, 5'd0);
      set_mags(5'b00010, 6000);
      exp_q.push_back('{pu: 5'b00010, id: 3'd1});
      hist_pulse();
      wait_grant(40, lat);
      chk("t2_latency", lat, 17);
      frames(119);
      chk("t2_hold_119_pu", pu_out, 5'b00010);
      chk("t2_hold_119_id", active_id, 3'd1);
      frames(1);
      chk("t2_release_pu", pu_out, 5'd0);
      chk("t2_release_id", active_id, 3'd7);
      chk("t2_cooldown_busy", busy, 1'b1);
      frames(299);
      chk("t2_cool_299_busy", busy, 1'b1);
      frames(1);
      chk("t2_cool_done_busy", busy, 1'b0);
      step(5);
      chk("t2_no_regrant", pu_out, 5'd0);

      // Debounce broken by a quiet histogram; threshold boundary 4096 loud / 4095 quiet
      do_reset();
      apply_hist(5'b00100, 4096);
      apply_hist(5'b00100, 4095);
      apply_hist(5'b00100, 6000);
      apply_hist(5'b00100, 6000);
      chk("t4_no_grant", pu_out, 5'd0);
      chk("t4_not_busy", busy, 1'b0);
      set_mags(5'b00100, 4096);
      exp_q.push_back('{pu: 5'b00100, id: 3'd2});
      hist_pulse();
      wait_grant(40, lat);
      chk("t4_latency", lat, 17);

      // Two bands pending: rr=0 picks 0, then 3; rr then at 4
      do_reset();
      apply_hist(5'b01001, 6000);
      apply_hist(5'b01001, 6000);
      set_mags(5'b01001, 6000);
      exp_q.push_back('{pu: 5'b00001, id: 3'd0});
      hist_pulse();
      wait_grant(40, lat);
      chk("t3_latency", lat, 17);
      exp_q.push_back('{pu: 5'b01000, id: 3'd3});
      frames(120);
      chk("t3_release_pu", pu_out, 5'd0);
      frames(300);
      wait_grant(10, lat);
      // Disable mid-ACTIVE
      frames(10);
      enable = 1'b0;
      step(1);
      chk("t6_dis_pu", pu_out, 5'd0);
      chk("t6_dis_busy", busy, 1'b0);
      chk("t6_dis_id", active_id, 3'd7);
      step(3);
      enable = 1'b1;
      apply_hist(5'b10001, 6000);
      apply_hist(5'b10001, 6000);
      set_mags(5'b10001, 6000);
      exp_q.push_back('{pu: 5'b10000, id: 3'd4});
      hist_pulse();
      wait_grant(40, lat);
      chk("t3_rr4_latency", lat, 17);

      // Overrun, and zero-cooldown instance
      do_reset();
      apply_hist(5'b10000, 6000);
      apply_hist(5'b10000, 6000);
      set_mags(5'b10000, 6000);
      exp_q.push_back('{pu: 5'b10000, id: 3'd4});
      hist_pulse();
      step(4);
      set_mags(5'b00000, 0);
      hist_done = 1'b1;
      step(1);
      hist_done = 1'b0;
      chk("t5_overrun_set", overrun, 1'b1);
      wait_grant(40, lat);
      chk("t5_latency", lat, 12);
      chk("t6_nc_grant", nc_pu_out, 5'b10000);
      frames(3);
      chk("t6_nc_hold_pu", nc_pu_out, 5'b10000);
      chk("t6_nc_hold_busy", nc_busy, 1'b1);
      frames(1);
      chk("t6_nc_release_pu", nc_pu_out, 5'd0);
      chk("t6_nc_release_busy", nc_busy, 1'b0);
      chk("t6_nc_release_id", nc_active_id, 3'd7);
      chk("t6_main_still_active", pu_out, 5'b10000);
      step(50);
      chk("t5_overrun_sticky", overrun, 1'b1);
      do_reset();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout observed=running expected=finished");
      $fatal(1, "watchdog");
   end

endmodule
